alu_seq_pipe: RTL and testbench
===============================

// Module: alu_seq_pipe
// PURPOSE
//  Parametrised, registered successor of the 4-bit-opcode ALU used by the execute stage.
//  Adds WIDTH generalisation, shift ops, valid/ready handshakes on both sides and registered
//  Z/N/C/V flags, with optional iterative multiply. Sits between issue and writeback;
//  one operation in flight; output register holds its result under backpressure.
// PARAMETERS
//  WIDTH   32   operand/result width (>=8, power of 2)
//  SHW     $clog2(WIDTH)   shift-amount width, taken from b[SHW-1:0]; localparam, not overridable
// PORTS
//  clk        in   1      single clock, all state on rising edge
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      operation request
//  in_ready   out  1      block can accept request this cycle
//  alu_op     in   4      opcode (table below)
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B / shift amount
//  out_valid  out  1      result+flags valid
//  out_ready  in   1      consumer takes result this cycle
//  s          out  WIDTH  result
//  z,n,c,v    out  1 ea.  zero, negative, carry, overflow flags
// BEHAVIOUR
//  Opcodes: 0100 ADD; 1010,0010 SUB (A-B); 0000 AND; 1100 OR; 0001 XOR; 1101 PASS B;
//   0011 SLL; 0101 SRL; 0111 SRA; 1000 MUL (macro only); all others -> s=0.
//  Reset: out_valid=0, s=0, z=1, n=0, c=0, v=0, state=IDLE, counter=0; in_ready=0 while rst high.
//  Accept: in_valid && in_ready at a rising edge. in_ready = (state==IDLE) && (!out_valid || out_ready).
//  Single-cycle ops: accepted at edge k -> out_valid=1 with s/flags at edge k+1 (latency 1).
//  Throughput 1 op/cycle when out_ready held high (accept and drain in the same cycle allowed).
//  Backpressure: out_valid && !out_ready -> s, z, n, c, v, out_valid held stable; no accept.
//  Drain: out_valid && out_ready && no accept -> out_valid=0 next edge; s/flags keep value.
//  Flags: z = (s==0); n = s[WIDTH-1].
//   ADD: {c,s} = a+b (WIDTH+1 bit); v = (a[W-1]==b[W-1]) && (s[W-1]!=a[W-1]).
//   SUB: {c,s} = {1'b1,a}-b, so c=1 means no borrow (a>=b unsigned);
//        v = (a[W-1]!=b[W-1]) && (s[W-1]!=a[W-1]).
//   Logic/PASS/shift/default: c=0, v=0.
//  Shifts: amount = b[SHW-1:0]; upper b bits ignored; SRA replicates a[W-1]; amount 0 -> s=a.
//  FSM: IDLE -(accept MUL)-> BUSY -(counter==WIDTH-1)-> IDLE, with out_valid=1 at that edge.
//   All other accepts stay in IDLE.
//  Reset has priority over everything; rst mid-BUSY aborts the multiply with no output.
//  in_valid/operands ignored while in_ready=0; no request is queued.
// CONFIGURATION
//  ALU_SEQ_MUL_EN defined: opcode 1000 = unsigned MUL, one shift-add step per cycle.
//   Latency WIDTH: accept at edge k -> out_valid at edge k+WIDTH.
//   s = low WIDTH bits of a*b; c = 1 iff high WIDTH bits nonzero; v=0; z/n from s.
//   a/b captured at accept; later input changes have no effect.
//  ALU_SEQ_MUL_EN undefined: no BUSY state, no counter/multiplier registers.
//   1000 is an unsupported opcode: latency 1, s=0, z=1, n=0, c=0, v=0.
// TESTING (WIDTH=32 unless noted)
//  1 ADD a=7FFFFFFF,b=1, out_ready=1 -> next cycle s=80000000 z=0 n=1 c=0 v=1;
//    ADD FFFFFFFF+1 -> s=0 z=1 c=1 v=0.
//  2 SUB a=5,b=7 -> s=FFFFFFFE n=1 c=0 v=0; SUB 80000000-1 -> s=7FFFFFFF c=1 v=1; opcode 0010 gives same.
//  3 SRA a=80000000,b=0000_0024 (amount 4) -> s=F8000000; SLL amount 0 -> s=a; SRL a=F0,b=4 -> s=0F.
//  4 Back-to-back ADD,XOR,OR with out_ready=1 -> one result per cycle, in order.
//    out_ready=0 for 3 cycles -> s/flags frozen, in_ready=0; release -> next op accepted same cycle.
//  5 With ALU_SEQ_MUL_EN: MUL 0001_0000*0001_0000 -> after 32 cycles s=0 z=1 c=1;
//    in_ready=0 throughout. rst at cycle 10 -> out_valid stays 0, z=1, IDLE; next ADD accepted.
//  6 Without ALU_SEQ_MUL_EN: opcode 1000 and 1111 -> latency 1, s=0 z=1 n=0 c=0 v=0.
//    Repeat 1-3 at WIDTH=8: ADD 7F+01 -> s=80 v=1.

Source files
------------

// File: rtl/alu_seq_pipe.sv
// alu_seq_pipe: registered ALU with valid/ready handshakes and Z/N/C/V flags.
// Define ALU_SEQ_MUL_EN to enable the iterative shift-add unsigned multiply on opcode 1000.
module alu_seq_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             z,
  output logic             n,
  output logic             c,
  output logic             v
);
  localparam int SHW = $clog2(WIDTH);

  logic [WIDTH-1:0] s_reg, res_next, mul_s;
  logic             out_valid_reg, z_reg, n_reg, c_reg, v_reg;
  logic             c_next, v_next;
  logic             idle, accept, start_mul, mul_done, mul_c;
  logic [WIDTH:0]   sum, diff;
  logic [SHW-1:0]   shamt;

  assign in_ready = !rst && idle && (!out_valid_reg || out_ready);
  assign accept   = in_valid && in_ready;
  assign shamt    = b[SHW-1:0];
  assign sum      = {1'b0, a} + {1'b0, b};
  // Borrow-in of 1 makes the top bit a "no borrow" carry.
  assign diff     = {1'b1, a} - {1'b0, b};

  always_comb begin
    res_next = '0;
    c_next   = 1'b0;
    v_next   = 1'b0;
    case (alu_op)
      4'b0100: begin
        res_next = sum[WIDTH-1:0];
        c_next   = sum[WIDTH];
        v_next   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      4'b1010, 4'b0010: begin
        res_next = diff[WIDTH-1:0];
        c_next   = diff[WIDTH];
        v_next   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      4'b0000: res_next = a & b;
      4'b1100: res_next = a | b;
      4'b0001: res_next = a ^ b;
      4'b1101: res_next = b;
      4'b0011: res_next = a << shamt;
      4'b0101: res_next = a >> shamt;
      4'b0111: res_next = $unsigned($signed(a) >>> shamt);
      default: res_next = '0;
    endcase
  end

`ifdef ALU_SEQ_MUL_EN
  typedef enum logic {IDLE, BUSY} state_t;
  state_t               state_reg, state_next;
  logic [SHW-1:0]       count_reg;
  logic [2*WIDTH-1:0]   acc_reg, mcand_reg, acc_next;
  logic [WIDTH-1:0]     mplier_reg;

  assign idle      = (state_reg == IDLE);
  assign start_mul = accept && (alu_op == 4'b1000);
  assign acc_next  = acc_reg + (mplier_reg[0] ? mcand_reg : '0);
  // The last step lands on the edge that also publishes the product.
  assign mul_done  = (state_reg == BUSY) && (count_reg == SHW'(WIDTH - 1));
  assign mul_s     = acc_next[WIDTH-1:0];
  assign mul_c     = |acc_next[2*WIDTH-1:WIDTH];

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start_mul) state_next = BUSY;
      BUSY:    if (mul_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      count_reg  <= '0;
      acc_reg    <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (start_mul) begin
        count_reg  <= '0;
        acc_reg    <= '0;
        mcand_reg  <= {{WIDTH{1'b0}}, a};
        mplier_reg <= b;
      end else if (state_reg == BUSY) begin
        count_reg  <= count_reg + SHW'(1);
        acc_reg    <= acc_next;
        mcand_reg  <= mcand_reg << 1;
        mplier_reg <= mplier_reg >> 1;
      end
    end
  end
`else
  assign idle      = 1'b1;
  assign start_mul = 1'b0;
  assign mul_done  = 1'b0;
  assign mul_s     = '0;
  assign mul_c     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      s_reg         <= '0;
      z_reg         <= 1'b1;
      n_reg         <= 1'b0;
      c_reg         <= 1'b0;
      v_reg         <= 1'b0;
    end else if (accept && !start_mul) begin
      out_valid_reg <= 1'b1;
      s_reg         <= res_next;
      z_reg         <= (res_next == '0);
      n_reg         <= res_next[WIDTH-1];
      c_reg         <= c_next;
      v_reg         <= v_next;
    end else if (mul_done) begin
      out_valid_reg <= 1'b1;
      s_reg         <= mul_s;
      z_reg         <= (mul_s == '0);
      n_reg         <= mul_s[WIDTH-1];
      c_reg         <= mul_c;
      v_reg         <= 1'b0;
    end else if (out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign out_valid = out_valid_reg;
  assign s         = s_reg;
  assign z         = z_reg;
  assign n         = n_reg;
  assign c         = c_reg;
  assign v         = v_reg;
endmodule

// File: tb/tb_alu_seq_pipe.sv
// Scoreboard bench for alu_seq_pipe: driver pushes model results, monitor pops on each transfer.
`timescale 1ns/1ps
module tb_alu_seq_pipe;
  localparam int W = 32;
  localparam longint MAXS = (longint'(1) <<< (W - 1)) - 1;
  localparam longint MINS = -(longint'(1) <<< (W - 1));

  logic         clk = 1'b0, rst = 1'b1;
  logic         in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
  logic [3:0]   alu_op = 4'd0;
  logic [W-1:0] a = '0, b = '0, s;
  logic         z, n, c, v;

  logic         in_valid8 = 1'b0, in_ready8, out_valid8;
  logic [3:0]   alu_op8 = 4'd0;
  logic [7:0]   a8 = '0, b8 = '0, s8;
  logic         z8, n8, c8, v8;

  alu_seq_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .alu_op(alu_op),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .z(z), .n(n), .c(c), .v(v));

  alu_seq_pipe #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .alu_op(alu_op8),
    .a(a8), .b(b8), .out_valid(out_valid8), .out_ready(1'b1),
    .s(s8), .z(z8), .n(n8), .c(c8), .v(v8));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] s;
    logic z, n, c, v;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0, errors = 0;
  bit   bp_random = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic bit is_mul(input logic [3:0] op);
`ifdef ALU_SEQ_MUL_EN
    return op == 4'b1000;
`else
    return 1'b0;
`endif
  endfunction

  // Reference: plain arithmetic on wide integers, flags from range checks.
  function automatic exp_t ref_model(input logic [3:0] op, input logic [W-1:0] x,
                                     input logic [W-1:0] y);
    exp_t e;
    longint sx, sy, r;
    logic [63:0] wide;
    int amt;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    amt = int'(y % W);
    e.s = '0; e.c = 1'b0; e.v = 1'b0;
    case (op)
      4'b0100: begin
        wide = 64'(x) + 64'(y);
        e.s = wide[W-1:0];
        e.c = (wide >> W) != 0;
        r = sx + sy;
        e.v = (r > MAXS) || (r < MINS);
      end
      4'b1010, 4'b0010: begin
        e.s = x - y;
        e.c = (x >= y);
        r = sx - sy;
        e.v = (r > MAXS) || (r < MINS);
      end
      4'b0000: e.s = x & y;
      4'b1100: e.s = x | y;
      4'b0001: e.s = x ^ y;
      4'b1101: e.s = y;
      4'b0011: e.s = W'(64'(x) << amt);
      4'b0101: e.s = x >> amt;
      4'b0111: e.s = W'(sx >>> amt);
`ifdef ALU_SEQ_MUL_EN
      4'b1000: begin
        wide = 64'(x) * 64'(y);
        e.s = wide[W-1:0];
        e.c = (wide >> W) != 0;
      end
`endif
      default: e.s = '0;
    endcase
    e.z = (e.s == '0);
    e.n = e.s[W-1];
    return e;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic issue(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                       output int waited);
    bit got = 1'b0;
    alu_op = op; a = x; b = y; in_valid = 1'b1; waited = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (in_ready) got = 1'b1;
      else waited++;
    end
    if (got) exp_q.push_back(ref_model(op, x, y));
    else begin
      checks++; errors++;
      $display("FAIL accept_timeout op=%0h waited=%0d required=accept", op, waited);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; a = $urandom; b = $urandom;
    if (got && !is_mul(op)) chk("latency1_out_valid", 64'(out_valid), 64'd1);
  endtask

  function automatic logic [W-1:0] rnd_val();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Monitor: pops on every transfer, checks hold under backpressure.
  initial begin
    logic [37:0] hold_val;
    bit hold_pending = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && hold_pending)
        chk("hold_stable", 64'({out_valid, s, z, n, c, v}), 64'(hold_val));
      hold_pending = !rst && out_valid && !out_ready;
      hold_val = {out_valid, s, z, n, c, v};
      if (!rst && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_output s=%h required=no_output", s);
        end else begin
          e = exp_q.pop_front();
          $display("txn s=%h z=%b n=%b c=%b v=%b", s, z, n, c, v);
          chk("result_szncv", 64'({s, z, n, c, v}), 64'(e));
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (bp_random) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic op8(input logic [3:0] op, input logic [7:0] x, input logic [7:0] y,
                     input logic [11:0] req, input string name);
    @(negedge clk);
    chk("w8_in_ready", 64'(in_ready8), 64'd1);
    @(posedge clk); #1;
    alu_op8 = op; a8 = x; b8 = y; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    chk(name, 64'({out_valid8, s8, z8, n8, c8, v8}), 64'({1'b1, req[11:4], req[3:0]}));
  endtask

  initial begin
    int w;
    repeat (2) @(negedge clk);
    chk("rst_in_ready_low", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_state", 64'({out_valid, s, z, n, c, v}), 64'({1'b0, 32'h0, 4'b1000}));
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // Directed corner cases
    issue(4'b0100, 32'h7FFF_FFFF, 32'h1, w);
    chk("add_ovf_const", 64'({s, z, n, c, v}), 64'({32'h8000_0000, 4'b0101}));
    issue(4'b0100, 32'hFFFF_FFFF, 32'h1, w);
    chk("add_carry_const", 64'({s, z, n, c, v}), 64'({32'h0, 4'b1010}));
    issue(4'b1010, 32'h5, 32'h7, w);
    chk("sub_borrow_const", 64'({s, z, n, c, v}), 64'({32'hFFFF_FFFE, 4'b0100}));
    issue(4'b1010, 32'h8000_0000, 32'h1, w);
    issue(4'b0010, 32'h8000_0000, 32'h1, w);
    chk("sub_alt_const", 64'({s, z, n, c, v}), 64'({32'h7FFF_FFFF, 4'b0011}));
    issue(4'b0111, 32'h8000_0000, 32'h24, w);
    chk("sra_const", 64'(s), 64'h F800_0000);
    issue(4'b0011, 32'h1234_5678, 32'h20, w);
    issue(4'b0101, 32'hF0, 32'h4, w);
    issue(4'b1111, 32'hDEAD_BEEF, 32'h1234, w);
    chk("unsupported_const", 64'({s, z, n, c, v}), 64'({32'h0, 4'b1000}));
`ifndef ALU_SEQ_MUL_EN
    issue(4'b1000, 32'h0001_0000, 32'h0001_0000, w);
    chk("op1000_unsup_const", 64'({s, z, n, c, v}), 64'({32'h0, 4'b1000}));
`endif

    // Back-to-back at full throughput
    issue(4'b0100, 32'h1111, 32'h2222, w);
    issue(4'b0001, 32'hFF00, 32'h0FF0, w);
    chk("b2b_xor_wait", 64'(w), 64'd0);
    issue(4'b1100, 32'hF000, 32'h000F, w);
    chk("b2b_or_wait", 64'(w), 64'd0);

    // Backpressure for 3 cycles, then release with a pending request
    out_ready = 1'b0;
    alu_op = 4'b0000; a = 32'hFF0F; b = 32'h0FF0; in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready_low", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    issue(4'b0000, 32'hFF0F, 32'h0FF0, w);
    chk("release_same_cycle", 64'(w), 64'd0);

`ifdef ALU_SEQ_MUL_EN
    issue(4'b1000, 32'h0001_0000, 32'h0001_0000, w);
    for (int i = 1; i < W; i++) begin
      @(posedge clk); #1;
      chk("mul_busy_no_valid", 64'(out_valid), 64'd0);
      chk("mul_busy_in_ready", 64'(in_ready), 64'd0);
    end
    @(posedge clk); #1;
    chk("mul_latency_valid", 64'(out_valid), 64'd1);
    chk("mul_result_const", 64'({s, z, n, c, v}), 64'({32'h0, 4'b1010}));
    issue(4'b1000, 32'h3, 32'h5, w);
    repeat (9) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    void'(exp_q.pop_back());
    chk("abort_state", 64'({out_valid, z}), 64'({1'b0, 1'b1}));
    repeat (W + 4) begin
      @(negedge clk);
      chk("abort_no_output", 64'(out_valid), 64'd0);
    end
    @(posedge clk); #1;
    issue(4'b0100, 32'h10, 32'h20, w);
    chk("after_abort_accept", 64'(w), 64'd0);
`endif

    // Randomised traffic with random backpressure
    bp_random = 1'b1;
    for (int i = 0; i < 300; i++) begin
      issue(4'($urandom_range(0, 15)), rnd_val(), rnd_val(), w);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    bp_random = 1'b0;
    out_ready = 1'b1;
    repeat (W + 5) begin @(posedge clk); #1; end
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    // Narrow instance
    op8(4'b0100, 8'h7F, 8'h01, {8'h80, 4'b0101}, "w8_add_ovf");
    op8(4'b1010, 8'h05, 8'h07, {8'hFE, 4'b0100}, "w8_sub");
    op8(4'b0111, 8'h80, 8'h0C, {8'hF8, 4'b0100}, "w8_sra");
    op8(4'b0011, 8'h5A, 8'h08, {8'h5A, 4'b0000}, "w8_sll_zero");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
